instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
// - Front end feeding ControlUnit: holds PC, MAR and IR; runs req/ack read of instruction memory.
// - Consumes CU strobes (PC_en/PC_load, PC_inc, MAR_load, IR_load).
// - Returns command_word, PC_current_value and ReadyRegFlag; the CU enters DECODE when ReadyRegFlag=0.
// - One outstanding read; ack-timeout guard substitutes NOP word and flags error.
// PARAMETERS
// - ADDR_W    8     PC/MAR/memory address width
// - WORD_W    24    instruction width {opcode[23:16], op1[15:8], op2[7:0]}
// - RESET_PC  8'h00 PC value after reset
// - TIMEOUT   15    max cycles in REQ waiting for mem_rd_ack (>=1)
// PORTS
// - clk               in   1       rising-edge clock
// - rst               in   1       reset, asynchronous, active-high
// - PC_en             in   1       load PC from PC_load (jump/ret/reset vector)
// - PC_load           in   ADDR_W  PC load value
// - PC_inc            in   1       level from CU; PC increments on its 0->1 transition only
// - MAR_load          in   1       level request: copy PC to MAR and start fetch
// - IR_load           in   1       level request: transfer fetched word to IR
// - mem_addr          out  ADDR_W  instruction memory address (=MAR)
// - mem_rd_req        out  1       read request, held until ack or timeout
// - mem_rd_ack        in   1       memory: mem_rd_data valid this cycle
// - mem_rd_data       in   WORD_W  instruction word
// - command_word      out  WORD_W  IR contents
// - PC_current_value  out  ADDR_W  PC register
// - ReadyRegFlag      out  1       1 = IR not yet valid for current fetch (busy); 0 = IR valid
// - fetch_err         out  1       sticky: a fetch timed out; cleared by rst only
// BEHAVIOUR
// - Reset (async): PC=RESET_PC, MAR=0, IR=0, buf=0, mem_rd_req=0, ReadyRegFlag=1, fetch_err=0.
//   Also clears: inc_prev=0, fetch_done=0, state=IDLE, timer=0.
// - PC update priority: PC_en > PC_inc edge. PC_en: PC<=PC_load. Edge (PC_inc & ~inc_prev): PC<=PC+1.
//   PC wraps 8'hFF->8'h00. inc_prev registered every cycle.
//   PC_inc held high => exactly one increment. PC_en and inc edge in same cycle: load wins, edge consumed.
// - fetch_done: set on data capture; cleared in any cycle PC changes (load or increment).
// - FSM IDLE/REQ/DONE:
//   - IDLE: when MAR_load=1 and fetch_done=0: MAR<=PC (pre-update value), ReadyRegFlag<=1, ->REQ.
//   - REQ: mem_rd_req=1, mem_addr=MAR, timer++.
//     - On mem_rd_ack: buf<=mem_rd_data, fetch_done<=1, ->DONE. Ack in first REQ cycle is legal (1-cycle memory).
//     - On timer==TIMEOUT-1 with no ack: buf<=24'h000000 (NOP), fetch_err<=1, fetch_done<=1, ->DONE.
//   - DONE: when IR_load=1: IR<=buf, ReadyRegFlag<=0, ->IDLE.
//     - IR_load may be high before data arrives: transfer happens the first DONE cycle with IR_load=1.
// - Latency: MAR_load rise -> mem_rd_req next cycle. Ack cycle N -> DONE N+1. IR/ReadyRegFlag=0 at N+2 if IR_load held.
// - MAR_load/PC_en/PC_inc during REQ/DONE: PC updates normally; MAR, request and buf untouched.
//   After return to IDLE, cleared fetch_done causes a new fetch if MAR_load still high.
// - mem_rd_ack outside REQ: ignored (covers late ack after timeout or reset).
// - Reset mid-REQ: mem_rd_req drops immediately (asynchronous); no partial IR write.
// STRUCTURE
// - cpu_pkg: ADDR_W/WORD_W defaults, NOP_WORD=24'h000000, opcode localparams shared with CU, fetch_state_t enum {IDLE,REQ,DONE}.
// - Sub-module pc_counter: PC register, PC_en load, PC_inc edge detect, wrap; exposes pc_changed for fetch_done clear.
// - Top: FSM, MAR, buf, IR, timeout counter ($clog2(TIMEOUT+1) bits).
// TESTING
// - Reset, MAR_load=1, IR_load=1, memory acks 2 cycles after req with 24'h010305:
//   -> mem_addr=0, command_word=24'h010305, ReadyRegFlag 1->0.
// - PC_inc held high 5 cycles -> PC advances by exactly 1.
//   PC_en=1 with PC_load=8'h40 and PC_inc rising same cycle -> PC=8'h40.
// - PC=8'hFF, PC_inc edge -> PC=8'h00.
//   Next fetch with MAR_load high -> mem_addr=8'h00.
// - No ack for TIMEOUT cycles -> mem_rd_req drops, command_word=24'h000000, fetch_err=1.
//   Later stray ack ignored; IR unchanged.
// - rst pulsed while mem_rd_req=1 -> req low same cycle; PC=RESET_PC, ReadyRegFlag=1; subsequent ack ignored.
// - Ack arrives while IR_load=0 -> IR holds old word, ReadyRegFlag=1.
//   IR_load raised 3 cycles later -> IR updates next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, instruction encoding constants and the
// fetch state type used by the instruction front end and the control unit.
package cpu_pkg;

   localparam int          ADDR_W_DEF   = 8;
   localparam int          WORD_W_DEF   = 24;
   localparam int          TIMEOUT_DEF  = 15;
   localparam logic [7:0]  RESET_PC_DEF = 8'h00;

   // Word substituted for a fetch that never got an ack
   localparam logic [23:0] NOP_WORD = 24'h000000;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_LOAD = 8'h01;
   localparam logic [7:0] OP_STORE = 8'h02;
   localparam logic [7:0] OP_ADD  = 8'h03;
   localparam logic [7:0] OP_SUB  = 8'h04;
   localparam logic [7:0] OP_JMP  = 8'h05;
   localparam logic [7:0] OP_CALL = 8'h06;
   localparam logic [7:0] OP_RET  = 8'h07;
   localparam logic [7:0] OP_HALT = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter: direct load has priority over a single-step increment that
// fires only on the rising edge of the increment level from the control unit.
module pc_counter #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pc_en,
   input  logic [ADDR_W-1:0] pc_load,
   input  logic              pc_inc,
   output logic [ADDR_W-1:0] pc,
   output logic              pc_changed
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              inc_prev_q, inc_prev_d;
   logic              inc_edge;

   always_comb begin
      inc_edge   = pc_inc & ~inc_prev_q;
      inc_prev_d = pc_inc;
      pc_d       = pc_q;
      pc_changed = 1'b0;
      // A load in the same cycle as an edge swallows the edge
      if (pc_en) begin
         pc_d       = pc_load;
         pc_changed = 1'b1;
      end else if (inc_edge) begin
         pc_d       = pc_q + ADDR_W'(1);
         pc_changed = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         inc_prev_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         inc_prev_q <= inc_prev_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction front end: owns PC, MAR and IR and runs a single-outstanding
// req/ack read of instruction memory with an ack-timeout fallback to NOP.
module instruction_fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                WORD_W   = WORD_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
   parameter int                TIMEOUT  = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              PC_en,
   input  logic [ADDR_W-1:0] PC_load,
   input  logic              PC_inc,
   input  logic              MAR_load,
   input  logic              IR_load,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_req,
   input  logic              mem_rd_ack,
   input  logic [WORD_W-1:0] mem_rd_data,
   output logic [WORD_W-1:0] command_word,
   output logic [ADDR_W-1:0] PC_current_value,
   output logic              ReadyRegFlag,
   output logic              fetch_err
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic [WORD_W-1:0] fbuf_q, fbuf_d;
   logic [WORD_W-1:0] ir_q, ir_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              rdy_q, rdy_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic [ADDR_W-1:0] pc;
   logic              pc_changed;

   pc_counter #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk        (clk),
      .rst        (rst),
      .pc_en      (PC_en),
      .pc_load    (PC_load),
      .pc_inc     (PC_inc),
      .pc         (pc),
      .pc_changed (pc_changed)
   );

   always_comb begin
      state_d = state_q;
      mar_d   = mar_q;
      fbuf_d  = fbuf_q;
      ir_d    = ir_q;
      timer_d = timer_q;
      rdy_d   = rdy_q;
      err_d   = err_q;
      done_d  = done_q;
      unique case (state_q)
         IDLE: begin
            // fetch_done blocks re-fetching the same PC while MAR_load stays high
            if (MAR_load && !done_q) begin
               mar_d   = pc;
               rdy_d   = 1'b1;
               timer_d = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            if (mem_rd_ack) begin
               fbuf_d  = mem_rd_data;
               done_d  = 1'b1;
               timer_d = '0;
               state_d = DONE;
            end else if (timer_q == TMR_LAST) begin
               fbuf_d  = WORD_W'(NOP_WORD);
               err_d   = 1'b1;
               done_d  = 1'b1;
               timer_d = '0;
               state_d = DONE;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         DONE: begin
            if (IR_load) begin
               ir_d    = fbuf_q;
               rdy_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A PC move invalidates the captured word for the next IDLE decision
      if (pc_changed) begin
         done_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mar_q   <= '0;
         fbuf_q  <= '0;
         ir_q    <= '0;
         timer_q <= '0;
         rdy_q   <= 1'b1;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mar_q   <= mar_d;
         fbuf_q  <= fbuf_d;
         ir_q    <= ir_d;
         timer_q <= timer_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign mem_addr         = mar_q;
   assign mem_rd_req       = (state_q == REQ);
   assign command_word     = ir_q;
   assign PC_current_value = pc;
   assign ReadyRegFlag     = rdy_q;
   assign fetch_err        = err_q;

endmodule
